add_seq32: RTL and testbench

Byte-serial multi-cycle adder controller. It accepts two N_BYTES-wide operands over a valid/ready handshake and sequences one shared 8-bit CLA slice over them, least-significant byte first. The inter-byte carry is held in a register between cycles. It sits in the ALU path as the low-area alternative to a full-width parallel adder, and returns sum, carry-out and signed overflow over a second valid/ready handshake.

---
 rtl/add_seq32_pkg.sv | 17 +
 rtl/add_seq32_if.sv | 32 +++
 rtl/add_seq32_add8.sv | 29 ++
 rtl/add_seq32.sv | 113 +++++++++++
 tb/tb_add_seq32.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/add_seq32_pkg.sv
// Shared types and constants for the byte-serial adder.
// Counter width helper sizes the byte index register.
package add_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SLICE_W = 8;

  function automatic int cnt_w(input int n_bytes);
    return $clog2(n_bytes);
  endfunction

endpackage

// File: rtl/add_seq32_if.sv
// Command/result handshake bundle for add_seq32.
// master = producer/consumer side, slave = the adder.
interface add_seq32_if
  import add_seq_pkg::*;
#(
  parameter int N_BYTES = 4
);
  localparam int W = SLICE_W * N_BYTES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] s;
  logic         cout;
  logic         ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, s, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, s, cout, ovf
  );

endinterface

// File: rtl/add_seq32_add8.sv
// 8-bit carry-lookahead slice add8 shared by add_seq32.
// Carries are formed from generate/propagate terms.
module add8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       c_1,
  output logic [7:0] s,
  output logic       c7
);

  logic [7:0] g;
  logic [7:0] p;
  logic [8:0] c;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    c    = '0;
    c[0] = c_1;
    for (int i = 0; i < 8; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
  end

  assign s  = p ^ c[7:0];
  assign c7 = c[8];

endmodule

// File: rtl/add_seq32.sv
// Byte-serial adder: one add8 slice walked LSB-first over N_BYTES.
// Define ADD_SEQ_SUB_EN to enable subtract via the sub input.
module add_seq32
  import add_seq_pkg::*;
#(
  parameter int N_BYTES = 4
) (
  input  logic     clk,
  input  logic     rst,
  add_seq32_if.slave bus
);

  localparam int W  = SLICE_W * N_BYTES;
  localparam int CW = cnt_w(N_BYTES);
  localparam logic [CW-1:0] LAST = CW'(N_BYTES - 1);

  state_t       state_q;
  logic [W-1:0] a_q;
  logic [W-1:0] b_q;
  logic [W-1:0] s_q;
  logic [CW-1:0] idx_q;
  logic         c_q;
  logic         cout_q;
  logic         ovf_q;
  logic         in_ready_q;
  logic         out_valid_q;

  logic [7:0]   sum_d;
  logic         c_d;
  logic         ovf_d;

  add8 u_add8 (
    .a   (a_q[7:0]),
    .b   (b_q[7:0]),
    .c_1 (c_q),
    .s   (sum_d),
    .c7  (c_d)
  );

  // Sign rule on the top byte; b_q already holds the inverted operand.
  assign ovf_d = (a_q[7] == b_q[7]) && (sum_d[7] != a_q[7]);

`ifndef ADD_SEQ_SUB_EN
  logic unused_sub;
  assign unused_sub = bus.sub;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      s_q         <= '0;
      idx_q       <= '0;
      c_q         <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q        <= bus.a;
`ifdef ADD_SEQ_SUB_EN
            if (bus.sub) begin
              b_q <= ~bus.b;
              c_q <= 1'b1;
            end else begin
              b_q <= bus.b;
              c_q <= bus.cin;
            end
`else
            b_q        <= bus.b;
            c_q        <= bus.cin;
`endif
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          a_q   <= a_q >> SLICE_W;
          b_q   <= b_q >> SLICE_W;
          s_q   <= {sum_d, s_q[W-1:SLICE_W]};
          c_q   <= c_d;
          idx_q <= idx_q + 1'b1;
          if (idx_q == LAST) begin
            cout_q      <= c_d;
            ovf_q       <= ovf_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.s         = s_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_add_seq32.sv
// Directed bench for add_seq32 (N_BYTES=4) with an arithmetic
// reference model and a scoreboard checked every result cycle.
module tb_add_seq32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  add_seq32_if #(.N_BYTES(4)) bus ();

  add_seq32 #(.N_BYTES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  logic [33:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
  endtask

  // {ovf, cout, s} from plain W+1-bit arithmetic.
  function automatic logic [33:0] model(input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic cin,
                                        input logic sub);
    logic [31:0] bb;
    logic        c;
    logic [32:0] r;
    logic        o;
    bb = b;
    c  = cin;
`ifdef ADD_SEQ_SUB_EN
    if (sub) begin
      bb = ~b;
      c  = 1'b1;
    end
`else
    if (sub) c = cin;
`endif
    r = {1'b0, a} + {1'b0, bb} + {32'd0, c};
    o = (a[31] == bb[31]) && (r[31] != a[31]);
    return {o, r};
  endfunction

  // Scoreboard compare on the falling edge.
  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", {63'd0, bus.out_valid}, 64'd0);
      end else begin
        check("sb_s", {32'd0, bus.s}, {32'd0, exp_q[0][31:0]});
        check("sb_cout", {63'd0, bus.cout}, {63'd0, exp_q[0][32]});
        check("sb_ovf", {63'd0, bus.ovf}, {63'd0, exp_q[0][33]});
        check("sb_in_ready_low", {63'd0, bus.in_ready}, 64'd0);
        if (bus.out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic cin, input logic sub);
    bit ok;
    ok = 1'b0;
    bus.a        = a;
    bus.b        = b;
    bus.cin      = cin;
    bus.sub      = sub;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk);
        exp_q.push_back(model(a, b, cin, sub));
        ok = 1'b1;
        break;
      end
    end
    #1 bus.in_valid = 1'b0;
    if (!ok) check("accept_timeout", {63'd0, bus.in_ready}, 64'd1);
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    for (int k = 1; k <= 50; k++) begin
      @(posedge clk);
      #1;
      lat = k;
      if (bus.out_valid) break;
    end
    check("out_valid_seen", {63'd0, bus.out_valid}, 64'd1);
  endtask

  task automatic take();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    check("consumed_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("idle_in_ready", {63'd0, bus.in_ready}, 64'd1);
  endtask

  int lat;
  logic [31:0] s_hold;

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a   = '0;
    bus.b   = '0;
    bus.cin = 1'b0;
    bus.sub = 1'b0;

    // Pin the model with literal results.
    check("model_basic", {30'd0, model(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0)},
          {30'd0, 2'b00, 32'h2345_6789});
    check("model_ovf", {30'd0, model(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0)},
          {30'd0, 2'b10, 32'h8000_0000});

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_s", {32'd0, bus.s}, 64'd0);
    check("rst_cout", {63'd0, bus.cout}, 64'd0);
    check("rst_ovf", {63'd0, bus.ovf}, 64'd0);
    rst = 1'b0;

    // Reset in the middle of RUN.
    issue(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    #1;
    check("midrst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("midrst_s", {32'd0, bus.s}, 64'd0);
    check("midrst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    issue(32'd2, 32'd3, 1'b0, 1'b0);
    wait_result(lat);
    check("after_rst_s", {32'd0, bus.s}, 64'd5);
    take();

    // Basic add and latency.
    issue(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    wait_result(lat);
    check("latency_edges", 64'(lat + 1), 64'd5);
    check("basic_s", {32'd0, bus.s}, 64'h2345_6789);
    check("basic_cout", {63'd0, bus.cout}, 64'd0);
    check("basic_ovf", {63'd0, bus.ovf}, 64'd0);
    take();

    // Carry ripples through every byte.
    issue(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
    wait_result(lat);
    check("ripple_s", {32'd0, bus.s}, 64'd0);
    check("ripple_cout", {63'd0, bus.cout}, 64'd1);
    check("ripple_ovf", {63'd0, bus.ovf}, 64'd0);
    take();

    // Positive overflow.
    issue(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
    wait_result(lat);
    check("ovf_s", {32'd0, bus.s}, 64'h8000_0000);
    check("ovf_ovf", {63'd0, bus.ovf}, 64'd1);
    check("ovf_cout", {63'd0, bus.cout}, 64'd0);
    take();

    // Negative overflow with carry out.
    issue(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
    wait_result(lat);
    check("negovf_s", {32'd0, bus.s}, 64'd0);
    check("negovf_cout", {63'd0, bus.cout}, 64'd1);
    check("negovf_ovf", {63'd0, bus.ovf}, 64'd1);
    take();

    // Backpressure in DONE with noise on the command side.
    issue(32'hDEAD_BEEF, 32'h0101_0101, 1'b1, 1'b0);
    wait_result(lat);
    s_hold = bus.s;
    check("bp_s", {32'd0, s_hold}, 64'hDFAE_BFF1);
    for (int k = 0; k < 10; k++) begin
      bus.a        = $urandom;
      bus.b        = $urandom;
      bus.in_valid = k[0];
      @(posedge clk);
      #1;
      check("bp_in_ready", {63'd0, bus.in_ready}, 64'd0);
      check("bp_hold_s", {32'd0, bus.s}, {32'd0, s_hold});
    end
    bus.in_valid = 1'b0;
    take();

    // Subtract request.
    issue(32'd5, 32'd7, 1'b0, 1'b1);
    wait_result(lat);
`ifdef ADD_SEQ_SUB_EN
    check("sub_s", {32'd0, bus.s}, 64'hFFFF_FFFE);
    check("sub_cout", {63'd0, bus.cout}, 64'd0);
    check("sub_ovf", {63'd0, bus.ovf}, 64'd0);
`else
    check("sub_off_s", {32'd0, bus.s}, 64'd12);
`endif
    take();

    repeat (3) @(posedge clk);
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
